// File: rtl/datapath_seq_pkg.sv
// Shared encodings for the sequenced datapath: control-word field codes and the
// memory sequencer state.
package datapath_seq_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC  = 2'b10,
    WB_RFB = 2'b11
  } wb_src_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_LOAD = 2'b10,
    PC_REL  = 2'b11
  } pc_fs_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // The reserved code behaves exactly like "no memory operation".
  function automatic logic is_mem_op(input mem_op_e op);
    return (op == MEM_READ) || (op == MEM_WRITE);
  endfunction

endpackage

// File: rtl/datapath_seq_if.sv
// System memory bus between the datapath sequencer (master) and memory (slave).
interface datapath_seq_if #(
  parameter int WIDTH = 64
) ();

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/regfile_param.sv
// Two-read / one-write register file; the highest register is hard-wired to zero.
module regfile_param #(
  parameter int WIDTH = 64,
  parameter int SELW  = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SELW-1:0]  sel_a,
  input  logic [SELW-1:0]  sel_b,
  input  logic             wr_en,
  input  logic [SELW-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_a,
  output logic [WIDTH-1:0] rd_b
);

  localparam int REG_COUNT = 2 ** SELW;
  localparam logic [SELW-1:0] ZERO_REG = SELW'(REG_COUNT - 1);

  logic [WIDTH-1:0] regs [REG_COUNT];

  // NOTE: this array is cleared by reset because software relies on all registers
  // reading zero afterwards; a plain RAM macro would not offer that.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != ZERO_REG)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_a = (sel_a == ZERO_REG) ? '0 : regs[sel_a];
  assign rd_b = (sel_b == ZERO_REG) ? '0 : regs[sel_b];

endmodule

// File: rtl/datapath_seq.sv
// Register file, PC and status register with a req/ack memory sequencer that
// tolerates multi-cycle memory; the ALU itself lives in the parent.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int          WIDTH    = 64,
  parameter int          SELW     = 5,
  parameter int unsigned MEM_TOP  = 5000,
  parameter int          TIMEOUT  = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic             clock,
  input  logic             reset,
  // control unit handshake and control word
  input  logic             cw_valid,
  output logic             cw_ready,
  input  logic [SELW-1:0]  rf_sel_a,
  input  logic [SELW-1:0]  rf_sel_b,
  input  logic [SELW-1:0]  rf_wr_addr,
  input  logic             rf_write,
  input  logic             b_sel,
  input  logic [WIDTH-1:0] immediate,
  input  logic [1:0]       wb_src,
  input  logic [1:0]       mem_op,
  input  logic [1:0]       pc_fs,
  input  logic             pc_in_sel,
  input  logic             status_load,
  input  logic             error_clear,
  // external ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_f,
  input  logic [3:0]       alu_status,
  // system memory bus
  datapath_seq_if.master   mem,
  // architectural state
  output logic [WIDTH-1:0] pc,
  output logic [3:0]       status,
  output logic             bus_error
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] ADDR_TOP   = WIDTH'(MEM_TOP);
  localparam logic [WIDTH-1:0] STEP       = WIDTH'(PC_STEP);

  state_e state, state_nxt;

  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             we_q;
  logic [SELW-1:0]  dest_q;
  logic             dest_wr_q;

  mem_op_e op;
  wb_src_e wb;
  pc_fs_e  pfs;

  logic             transfer;
  logic             mem_accept;
  logic             addr_bad;
  logic             start_access;
  logic             access_done;
  logic             set_error;
  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;
  logic [WIDTH-1:0] pc_plus_step;
  logic [WIDTH-1:0] pc_nxt;
  logic             rf_wr_en;
  logic [SELW-1:0]  rf_wr_sel;
  logic [WIDTH-1:0] rf_wr_data;

  assign op  = mem_op_e'(mem_op);
  assign wb  = wb_src_e'(wb_src);
  assign pfs = pc_fs_e'(pc_fs);

  assign transfer     = cw_valid & cw_ready;
  assign mem_accept   = transfer & is_mem_op(op);
  assign addr_bad     = alu_f > ADDR_TOP;
  assign start_access = mem_accept & ~addr_bad;
  // Leaving ACCESS: either the memory answered or the timer ran out; ack wins a tie.
  assign access_done  = (state == ST_ACCESS) & (mem.mem_ack | (timer == TIMER_LAST));
  assign set_error    = (mem_accept & addr_bad)
                      | ((state == ST_ACCESS) & ~mem.mem_ack & (timer == TIMER_LAST));

  regfile_param #(
    .WIDTH (WIDTH),
    .SELW  (SELW)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .sel_a   (rf_sel_a),
    .sel_b   (rf_sel_b),
    .wr_en   (rf_wr_en),
    .wr_addr (rf_wr_sel),
    .wr_data (rf_wr_data),
    .rd_a    (rf_a),
    .rd_b    (rf_b)
  );

  assign alu_a = rf_a;
  assign alu_b = b_sel ? immediate : rf_b;

  // ---------------------------------------------------------------- FSM
  // NOTE: clocked blocks use non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_access) state_nxt = ST_ACCESS;
      ST_ACCESS: if (access_done)  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cw_ready      = (state == ST_IDLE);
    mem.mem_req   = (state == ST_ACCESS);
    mem.mem_we    = we_q;
    mem.mem_addr  = addr_q;
    mem.mem_wdata = wdata_q;
  end

  // ------------------------------------------------ writeback and next PC
  assign pc_plus_step = pc + STEP;

  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_sel  = rf_wr_addr;
    rf_wr_data = alu_f;
    if (state == ST_ACCESS) begin
      rf_wr_en   = mem.mem_ack & dest_wr_q;
      rf_wr_sel  = dest_q;
      rf_wr_data = mem.mem_rdata;
    end else if (transfer && !is_mem_op(op)) begin
      rf_wr_en = rf_write;
      case (wb)
        WB_ALU:  rf_wr_data = alu_f;
        WB_MEM:  rf_wr_data = '0;  // no read data exists outside a read access
        WB_PC:   rf_wr_data = pc_plus_step;
        WB_RFB:  rf_wr_data = rf_b;
        default: rf_wr_data = alu_f;
      endcase
    end
  end

  always_comb begin
    pc_nxt = pc;
    case (pfs)
      PC_HOLD: pc_nxt = pc;
      PC_INC:  pc_nxt = pc_plus_step;
      PC_LOAD: pc_nxt = pc_in_sel ? immediate : rf_a;
      PC_REL:  pc_nxt = pc + immediate;
      default: pc_nxt = pc;
    endcase
  end

  // --------------------------------------------- architectural registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc        <= WIDTH'(RESET_PC);
      status    <= '0;
      bus_error <= 1'b0;
    end else begin
      if (transfer) begin
        pc <= pc_nxt;
        if (status_load) status <= alu_status;
      end
      if (set_error)        bus_error <= 1'b1;
      else if (error_clear) bus_error <= 1'b0;
    end
  end

  // ------------------------------------------------- pending access state
  always_ff @(posedge clock) begin
    if (!reset) begin
      timer     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      dest_q    <= '0;
      dest_wr_q <= 1'b0;
    end else if (start_access) begin
      timer     <= '0;
      addr_q    <= alu_f;
      wdata_q   <= rf_b;
      we_q      <= (op == MEM_WRITE);
      dest_q    <= rf_wr_addr;
      dest_wr_q <= rf_write & (op == MEM_READ);
    end else if (state == ST_ACCESS) begin
      if (access_done) begin
        we_q      <= 1'b0;
        dest_wr_q <= 1'b0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq: reset, table-driven single-cycle ops,
// hand-written memory sequences, then randomized traffic against a rule model.
module tb_datapath_seq;

  localparam int WIDTH   = 64;
  localparam int SELW    = 5;
  localparam int TIMEOUT = 16;
  localparam logic [63:0] MEM_TOP = 64'd5000;

  logic              clock;
  logic              reset;
  logic              cw_valid;
  logic              cw_ready;
  logic [SELW-1:0]   rf_sel_a, rf_sel_b, rf_wr_addr;
  logic              rf_write, b_sel, pc_in_sel, status_load, error_clear;
  logic [WIDTH-1:0]  immediate, alu_a, alu_b, alu_f, pc;
  logic [1:0]        wb_src, mem_op, pc_fs;
  logic [3:0]        alu_status, status;
  logic              bus_error;

  datapath_seq_if #(.WIDTH(WIDTH)) mem_bus ();

  datapath_seq #(
    .WIDTH(WIDTH), .SELW(SELW), .MEM_TOP(5000), .TIMEOUT(TIMEOUT), .RESET_PC(0), .PC_STEP(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cw_valid    (cw_valid),
    .cw_ready    (cw_ready),
    .rf_sel_a    (rf_sel_a),
    .rf_sel_b    (rf_sel_b),
    .rf_wr_addr  (rf_wr_addr),
    .rf_write    (rf_write),
    .b_sel       (b_sel),
    .immediate   (immediate),
    .wb_src      (wb_src),
    .mem_op      (mem_op),
    .pc_fs       (pc_fs),
    .pc_in_sel   (pc_in_sel),
    .status_load (status_load),
    .error_clear (error_clear),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_f       (alu_f),
    .alu_status  (alu_status),
    .mem         (mem_bus),
    .pc          (pc),
    .status      (status),
    .bus_error   (bus_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cw_valid          = 1'b0;
    rf_sel_a          = '0;
    rf_sel_b          = '0;
    rf_wr_addr        = '0;
    rf_write          = 1'b0;
    b_sel             = 1'b0;
    immediate         = '0;
    wb_src            = 2'b00;
    mem_op            = 2'b00;
    pc_fs             = 2'b00;
    pc_in_sel         = 1'b0;
    status_load       = 1'b0;
    error_clear       = 1'b0;
    alu_f             = '0;
    alu_status        = '0;
    mem_bus.mem_rdata = '0;
    mem_bus.mem_ack   = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic read_reg(input logic [SELW-1:0] sel, output logic [63:0] val);
    rf_sel_b = sel;
    b_sel    = 1'b0;
    #1;
    val = alu_b;
  endtask

  // ---------------------------------------------------------------- model
  logic [63:0] m_regs [32];
  logic [63:0] m_pc, m_paddr, m_pwdata;
  logic [3:0]  m_status;
  logic        m_berr, m_busy, m_pwe, m_pwen;
  logic [4:0]  m_pdest;
  int          m_waited;

  function automatic logic [63:0] m_rd(input logic [4:0] s);
    return (s == 5'd31) ? 64'd0 : m_regs[s];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = '0; m_status = '0; m_berr = 1'b0; m_busy = 1'b0;
    m_paddr = '0; m_pwdata = '0; m_pwe = 1'b0; m_pwen = 1'b0; m_pdest = '0; m_waited = 0;
  endtask

  task automatic model_step();
    logic        set_err = 1'b0;
    logic [63:0] rfa = m_rd(rf_sel_a);
    logic [63:0] rfb = m_rd(rf_sel_b);
    logic [63:0] wbv, npc;
    if (!m_busy) begin
      if (cw_valid) begin
        case (wb_src)
          2'd0:    wbv = alu_f;
          2'd1:    wbv = 64'd0;
          2'd2:    wbv = m_pc + 64'd4;
          default: wbv = rfb;
        endcase
        case (pc_fs)
          2'd0:    npc = m_pc;
          2'd1:    npc = m_pc + 64'd4;
          2'd2:    npc = pc_in_sel ? immediate : rfa;
          default: npc = m_pc + immediate;
        endcase
        if (mem_op == 2'd1 || mem_op == 2'd2) begin
          if (alu_f > MEM_TOP) set_err = 1'b1;
          else begin
            m_busy = 1'b1; m_paddr = alu_f; m_pwdata = rfb; m_pwe = (mem_op == 2'd2);
            m_pdest = rf_wr_addr; m_pwen = rf_write && (mem_op == 2'd1); m_waited = 0;
          end
        end else if (rf_write && rf_wr_addr != 5'd31) begin
          m_regs[rf_wr_addr] = wbv;
        end
        m_pc = npc;
        if (status_load) m_status = alu_status;
      end
    end else if (mem_bus.mem_ack) begin
      if (m_pwen && m_pdest != 5'd31) m_regs[m_pdest] = mem_bus.mem_rdata;
      m_busy = 1'b0;
    end else begin
      m_waited++;
      if (m_waited == TIMEOUT) begin
        m_busy  = 1'b0;
        set_err = 1'b1;
      end
    end
    if (set_err) m_berr = 1'b1;
    else if (error_clear) m_berr = 1'b0;
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic        valid;
    logic [4:0]  sel_a, sel_b;
    logic        wr;
    logic [4:0]  wr_addr;
    logic        bsel;
    logic [1:0]  wb, pcfs;
    logic        pcin;
    logic [63:0] imm, f;
    logic [63:0] exp_a, exp_b, exp_pc;
    logic [4:0]  chk_reg;
    logic [63:0] exp_reg;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [63:0] v, acc;
    int          n;

    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    check("reset_pc", pc, 64'd0);
    check("reset_cw_ready", 64'(cw_ready), 64'd1);
    check("reset_mem_req", 64'(mem_bus.mem_req), 64'd0);
    check("reset_mem_we", 64'(mem_bus.mem_we), 64'd0);
    check("reset_bus_error", 64'(bus_error), 64'd0);
    check("reset_status", 64'(status), 64'd0);
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      read_reg(5'(i), v);
      acc |= v;
    end
    check("reset_regs_zero", acc, 64'd0);
    reset = 1'b1;

    // valid sel_a sel_b wr wr_addr bsel wb pcfs pcin imm f exp_a exp_b exp_pc chk exp_reg
    tbl[0] = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd1,  1'b0, 2'd0, 2'd1, 1'b0, 64'd0,     64'd5,    64'd0, 64'd0,  64'd4,     5'd1,  64'd5};
    tbl[1] = '{1'b1, 5'd1, 5'd0, 1'b1, 5'd2,  1'b1, 2'd0, 2'd1, 1'b0, 64'd3,     64'd8,    64'd5, 64'd3,  64'd8,     5'd2,  64'd8};
    tbl[2] = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd3,  1'b0, 2'd2, 2'd2, 1'b1, 64'h100,   64'd0,    64'd0, 64'd0,  64'h100,   5'd3,  64'd12};
    tbl[3] = '{1'b1, 5'd2, 5'd2, 1'b1, 5'd4,  1'b0, 2'd3, 2'd3, 1'b0, 64'h10,    64'd0,    64'd8, 64'd8,  64'h110,   5'd4,  64'd8};
    tbl[4] = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd5,  1'b0, 2'd0, 2'd0, 1'b0, 64'd0,     64'h77,   64'd0, 64'd0,  64'h110,   5'd5,  64'h77};
    tbl[5] = '{1'b1, 5'd1, 5'd0, 1'b1, 5'd5,  1'b0, 2'd1, 2'd2, 1'b0, 64'd0,     64'h99,   64'd5, 64'd0,  64'd5,     5'd5,  64'd0};
    tbl[6] = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd31, 1'b0, 2'd0, 2'd1, 1'b0, 64'd0,     64'hFF,   64'd0, 64'd0,  64'd9,     5'd31, 64'd0};
    tbl[7] = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd1,  1'b0, 2'd0, 2'd0, 1'b0, 64'd0,     64'h99,   64'd0, 64'd0,  64'd9,     5'd1,  64'd5};
    tbl[8] = '{1'b0, 5'd1, 5'd3, 1'b1, 5'd1,  1'b0, 2'd0, 2'd1, 1'b0, 64'd0,     64'h55,   64'd5, 64'd12, 64'd9,     5'd1,  64'd5};

    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      cw_valid   = tbl[i].valid;
      rf_sel_a   = tbl[i].sel_a;
      rf_sel_b   = tbl[i].sel_b;
      rf_write   = tbl[i].wr;
      rf_wr_addr = tbl[i].wr_addr;
      b_sel      = tbl[i].bsel;
      wb_src     = tbl[i].wb;
      pc_fs      = tbl[i].pcfs;
      pc_in_sel  = tbl[i].pcin;
      immediate  = tbl[i].imm;
      alu_f      = tbl[i].f;
      #1;
      check($sformatf("vec%0d_alu_a", i), alu_a, tbl[i].exp_a);
      check($sformatf("vec%0d_alu_b", i), alu_b, tbl[i].exp_b);
      tick();
      idle_inputs();
      check($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
      read_reg(tbl[i].chk_reg, v);
      check($sformatf("vec%0d_reg", i), v, tbl[i].exp_reg);
    end

    // Status register: loads only on a transfer with status_load.
    idle_inputs(); cw_valid = 1'b1; status_load = 1'b1; alu_status = 4'hA;
    tick(); idle_inputs();
    check("status_load", 64'(status), 64'hA);
    cw_valid = 1'b1; alu_status = 4'h5;
    tick(); idle_inputs();
    check("status_hold_no_load", 64'(status), 64'hA);
    status_load = 1'b1; alu_status = 4'h3;
    tick(); idle_inputs();
    check("status_hold_no_transfer", 64'(status), 64'hA);

    // Read with ack on the third access cycle.
    cw_valid = 1'b1; mem_op = 2'd1; alu_f = 64'h40; rf_write = 1'b1; rf_wr_addr = 5'd7;
    tick(); idle_inputs();
    check("rd_cw_ready_c1", 64'(cw_ready), 64'd0);
    check("rd_mem_req_c1", 64'(mem_bus.mem_req), 64'd1);
    check("rd_mem_addr", mem_bus.mem_addr, 64'h40);
    check("rd_mem_we", 64'(mem_bus.mem_we), 64'd0);
    tick();
    check("rd_cw_ready_c2", 64'(cw_ready), 64'd0);
    read_reg(5'd7, v);
    check("rd_dest_before_ack", v, 64'd0);
    tick();
    check("rd_cw_ready_c3", 64'(cw_ready), 64'd0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 64'hDEAD;
    tick(); idle_inputs();
    check("rd_cw_ready_after", 64'(cw_ready), 64'd1);
    check("rd_mem_req_after", 64'(mem_bus.mem_req), 64'd0);
    read_reg(5'd7, v);
    check("rd_dest_written", v, 64'hDEAD);

    // Out-of-range addresses and bus_error priority.
    cw_valid = 1'b1; mem_op = 2'd2; alu_f = 64'd5001;
    tick(); idle_inputs();
    check("oor_mem_req", 64'(mem_bus.mem_req), 64'd0);
    check("oor_bus_error", 64'(bus_error), 64'd1);
    check("oor_cw_ready", 64'(cw_ready), 64'd1);
    error_clear = 1'b1;
    tick(); idle_inputs();
    check("err_cleared", 64'(bus_error), 64'd0);
    cw_valid = 1'b1; mem_op = 2'd2; alu_f = 64'd6000; error_clear = 1'b1;
    tick(); idle_inputs();
    check("err_set_beats_clear", 64'(bus_error), 64'd1);
    error_clear = 1'b1;
    tick(); idle_inputs();
    // Highest legal address with a write; rf_write on a write must not touch r9.
    cw_valid = 1'b1; mem_op = 2'd2; alu_f = MEM_TOP; rf_sel_b = 5'd2; rf_write = 1'b1; rf_wr_addr = 5'd9;
    tick(); idle_inputs();
    check("wr_top_mem_req", 64'(mem_bus.mem_req), 64'd1);
    check("wr_top_mem_we", 64'(mem_bus.mem_we), 64'd1);
    check("wr_top_addr", mem_bus.mem_addr, MEM_TOP);
    check("wr_top_wdata", mem_bus.mem_wdata, 64'd8);
    check("wr_top_no_error", 64'(bus_error), 64'd0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 64'h1111;
    tick(); idle_inputs();
    check("wr_done_req", 64'(mem_bus.mem_req), 64'd0);
    check("wr_done_we", 64'(mem_bus.mem_we), 64'd0);
    read_reg(5'd9, v);
    check("wr_no_writeback", v, 64'd0);

    // Timeout: preload r8, then a read that never gets an ack.
    cw_valid = 1'b1; rf_write = 1'b1; rf_wr_addr = 5'd8; alu_f = 64'h1234;
    tick(); idle_inputs();
    cw_valid = 1'b1; mem_op = 2'd1; alu_f = 64'h80; rf_write = 1'b1; rf_wr_addr = 5'd8;
    tick(); idle_inputs();
    n = 0;
    while (mem_bus.mem_req && n < 40) begin
      n++;
      tick();
    end
    check("to_req_cycles", 64'(n), 64'd16);
    check("to_bus_error", 64'(bus_error), 64'd1);
    check("to_cw_ready", 64'(cw_ready), 64'd1);
    read_reg(5'd8, v);
    check("to_dest_unchanged", v, 64'h1234);
    error_clear = 1'b1;
    tick(); idle_inputs();
    // Ack on the final allowed cycle is accepted.
    cw_valid = 1'b1; mem_op = 2'd1; alu_f = 64'h88; rf_write = 1'b1; rf_wr_addr = 5'd8;
    tick(); idle_inputs();
    for (int c = 1; c < TIMEOUT; c++) tick();
    check("late_ack_req_c16", 64'(mem_bus.mem_req), 64'd1);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 64'hBEEF;
    tick(); idle_inputs();
    check("late_ack_req", 64'(mem_bus.mem_req), 64'd0);
    check("late_ack_no_error", 64'(bus_error), 64'd0);
    read_reg(5'd8, v);
    check("late_ack_data", v, 64'hBEEF);

    // PC wrap and zero register.
    cw_valid = 1'b1; pc_fs = 2'd2; pc_in_sel = 1'b1; immediate = 64'hFFFF_FFFF_FFFF_FFFC;
    tick(); idle_inputs();
    check("pc_load_top", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    cw_valid = 1'b1; pc_fs = 2'd3; immediate = 64'd8; rf_write = 1'b1; rf_wr_addr = 5'd31; alu_f = 64'h1234;
    tick(); idle_inputs();
    check("pc_wrap", pc, 64'd4);
    read_reg(5'd31, v);
    check("zero_reg", v, 64'd0);

    // Reset in the middle of an access.
    cw_valid = 1'b1; mem_op = 2'd1; alu_f = 64'h20; rf_write = 1'b1; rf_wr_addr = 5'd10;
    tick(); idle_inputs();
    check("mid_rst_req_before", 64'(mem_bus.mem_req), 64'd1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_req", 64'(mem_bus.mem_req), 64'd0);
    check("mid_rst_cw_ready", 64'(cw_ready), 64'd1);
    check("mid_rst_pc", pc, 64'd0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 64'h5A5A;
    tick(); idle_inputs();
    read_reg(5'd10, v);
    check("idle_ack_ignored", v, 64'd0);
    check("idle_ack_cw_ready", 64'(cw_ready), 64'd1);

    // Randomized traffic against the rule model, starting from the post-reset state.
    model_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int sel;
      cw_valid    = ($urandom_range(0, 3) != 0);
      rf_sel_a    = 5'($urandom_range(0, 31));
      rf_sel_b    = 5'($urandom_range(0, 31));
      rf_wr_addr  = 5'($urandom_range(0, 31));
      rf_write    = $urandom_range(0, 1) == 1;
      b_sel       = $urandom_range(0, 1) == 1;
      immediate   = {$urandom(), $urandom()};
      wb_src      = 2'($urandom_range(0, 3));
      mem_op      = 2'($urandom_range(0, 3));
      pc_fs       = 2'($urandom_range(0, 3));
      pc_in_sel   = $urandom_range(0, 1) == 1;
      status_load = $urandom_range(0, 1) == 1;
      error_clear = ($urandom_range(0, 7) == 0);
      alu_status  = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 9);
      if (sel < 7)       alu_f = 64'($urandom_range(0, 5100));
      else if (sel == 7) alu_f = MEM_TOP + 64'($urandom_range(0, 1));
      else               alu_f = {$urandom(), $urandom()};
      mem_bus.mem_ack   = ($urandom_range(0, 5) == 0);
      mem_bus.mem_rdata = {$urandom(), $urandom()};
      #1;
      check("rnd_cw_ready", 64'(cw_ready), 64'(!m_busy));
      check("rnd_mem_req", 64'(mem_bus.mem_req), 64'(m_busy));
      check("rnd_mem_we", 64'(mem_bus.mem_we), 64'(m_busy && m_pwe));
      check("rnd_pc", pc, m_pc);
      check("rnd_status", 64'(status), 64'(m_status));
      check("rnd_bus_error", 64'(bus_error), 64'(m_berr));
      check("rnd_alu_a", alu_a, m_rd(rf_sel_a));
      check("rnd_alu_b", alu_b, b_sel ? immediate : m_rd(rf_sel_b));
      if (m_busy) begin
        check("rnd_mem_addr", mem_bus.mem_addr, m_paddr);
        check("rnd_mem_wdata", mem_bus.mem_wdata, m_pwdata);
      end
      model_step();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
